change_dispenser_ctrl: RTL and testbench
========================================

CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4: eject pulse width in clock cycles (>=1).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000: cycles to wait for coin_ack after the pulse ends before declaring a jam.
REQ-003 SHALL have one clock and a synchronous, active-low reset, exactly as follows:
 - clk  in  1  sole clock; all state updates on its rising edge.
 - rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have these ports:
 - start  in  1  begin a transaction; sampled only in IDLE.
 - amount  in  9  change to pay, in cents (0..500).
 - coin_ack  in  1  1-cycle pulse from the hopper sensor: one coin dispensed (pre-synchronised).
 - empty_q / empty_d / empty_n  in  1 each  quarter, dime or nickel hopper is empty.
 - eject_q / eject_d / eject_n  out  1 each  coin-eject pulse to that hopper.
 - busy  out  1  a transaction is in progress.
 - done  out  1  1-cycle pulse at the end of every transaction.
 - error  out  1  1-cycle pulse, coincident with done, when change was not fully paid.
 - remaining  out  9  unpaid cents; holds its final value until the next start.
 - coin_count  out  7  coins dispensed in the current or last transaction.

Function
REQ-005 SHALL implement the FSM states IDLE, SELECT, EJECT, WAIT_ACK, FIN.
REQ-006 IDLE with start=1 SHALL:
 - load remaining=amount;
 - clear coin_count and all jam flags;
 - set busy;
 - go to SELECT.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 SELECT SHALL take one cycle and choose greedily, in priority order:
 - quarter if remaining>=25, empty_q=0 and quarter not jammed;
 - else dime if remaining>=10, empty_d=0 and dime not jammed;
 - else nickel if remaining>=5, empty_n=0 and nickel not jammed;
 - else go to FIN.
REQ-009 SELECT SHALL go straight to FIN when amount>500; no eject occurs and remaining=amount.
REQ-010 EJECT SHALL hold exactly one eject line high for PULSE_CYCLES cycles, then go to WAIT_ACK.
REQ-011 eject lines SHALL be one-hot or all zero at all times.
REQ-012 A coin_ack seen in EJECT or WAIT_ACK SHALL:
 - subtract the selected coin value from remaining;
 - increment coin_count;
 - go to SELECT on the cycle after the pulse completes.
 Only the first ack per coin counts; acks in any other state are ignored.
REQ-013 With no ack after ACK_TIMEOUT cycles in WAIT_ACK, the FSM SHALL set the jam flag for the selected coin, leave remaining unchanged, and return to SELECT.
REQ-014 FIN SHALL last one cycle: done=1, error=(remaining!=0), busy drops next cycle, return to IDLE.
REQ-015 Latency: amount=0 gives done at start+2 cycles; each coin costs 1 + PULSE_CYCLES + ack-wait cycles.
REQ-016 remaining SHALL never underflow. A residue below 5 (e.g. amount=3) ends the transaction with error=1.
REQ-017 An empty_* change during EJECT or WAIT_ACK SHALL NOT abort the coin in flight; it affects only the next SELECT.

Reset
REQ-018 rst_n=0 at a clock edge SHALL:
 - force IDLE;
 - set busy, done, error and all eject lines to 0;
 - set remaining=0 and coin_count=0;
 - clear all jam flags.
REQ-019 Reset mid-transaction SHALL abandon it with no done pulse; the first start after reset is served normally.

Structure
REQ-020 A shared package vending_pkg SHALL hold:
 - the coin-value constants NICKEL=5, DIME=10, QUARTER=25;
 - MAX_CHANGE=500;
 - the FSM state typedef;
 - the coin-select typedef.
REQ-021 One sub-module, coin_eject_timer, SHALL provide the PULSE_CYCLES pulse counter and the ACK_TIMEOUT counter. All else SHALL stay in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
 - amount=40, hoppers full, ack 3 cycles after each pulse -> quarter, dime, nickel in order; done, error=0, remaining=0, coin_count=3.
 - amount=30, empty_q=1 -> three dime pulses, no eject_q; coin_count=3, error=0.
 - amount=3 -> no eject; done and error at start+2; remaining=3.
 - amount=25, quarter never acked -> eject_q, timeout after ACK_TIMEOUT, then dime, dime, nickel acked; error=0, coin_count=3.
 - amount=505 -> no eject; done and error at start+2; remaining=505.
 - rst_n=0 during the EJECT of amount=40 -> next edge all outputs 0 and no done; then start with amount=5 -> one nickel, done, error=0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared constants and types for the change dispenser: coin values, the
// largest payable amount, FSM states and the coin selector.
package vending_pkg;

  localparam logic [8:0] NICKEL     = 9'd5;
  localparam logic [8:0] DIME       = 9'd10;
  localparam logic [8:0] QUARTER    = 9'd25;
  localparam logic [8:0] MAX_CHANGE = 9'd500;

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, FIN} state_e;
  typedef enum logic [1:0] {COIN_NONE, COIN_N, COIN_D, COIN_Q} coin_e;

  function automatic logic [8:0] coin_value(input coin_e c);
    case (c)
      COIN_Q:  return QUARTER;
      COIN_D:  return DIME;
      COIN_N:  return NICKEL;
      default: return 9'd0;
    endcase
  endfunction

  // Bit order {quarter, dime, nickel}; shared by eject lines and jam flags.
  function automatic logic [2:0] coin_mask(input coin_e c);
    case (c)
      COIN_Q:  return 3'b100;
      COIN_D:  return 3'b010;
      COIN_N:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/coin_eject_timer.sv
// Eject pulse-width counter and post-pulse ack timeout counter. Each counter
// runs while its enable is high and clears as soon as the enable drops.
module coin_eject_timer #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_en_i,
  input  logic wait_en_i,
  output logic pulse_last_o,
  output logic timeout_o
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);

  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [AW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    pulse_cnt_d = pulse_en_i ? pulse_cnt_q + 1'b1 : '0;
    wait_cnt_d  = wait_en_i  ? wait_cnt_q + 1'b1  : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign pulse_last_o = pulse_en_i && (pulse_cnt_q == PULSE_LAST);
  assign timeout_o    = wait_en_i  && (wait_cnt_q  == ACK_LAST);

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Greedy coin-change dispenser: picks quarter/dime/nickel each round, pulses
// the hopper, waits for its ack, and marks a coin jammed when no ack arrives.
module change_dispenser_ctrl
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       coin_ack,
  input  logic       empty_q,
  input  logic       empty_d,
  input  logic       empty_n,
  output logic       eject_q,
  output logic       eject_d,
  output logic       eject_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] remaining,
  output logic [6:0] coin_count
);

  state_e     state_q, state_d;
  coin_e      sel_q, sel_d;
  logic [8:0] rem_q, rem_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] jam_q, jam_d;
  logic       acked_q, acked_d;
  logic       pulse_last, timeout;

  coin_eject_timer #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse_en_i  (state_q == EJECT),
    .wait_en_i   (state_q == WAIT_ACK),
    .pulse_last_o(pulse_last),
    .timeout_o   (timeout)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    jam_d   = jam_q;
    acked_d = acked_q;
    case (state_q)
      IDLE: if (start) begin
        rem_d   = amount;
        cnt_d   = '0;
        jam_d   = '0;
        sel_d   = COIN_NONE;
        state_d = SELECT;
      end
      SELECT: begin
        acked_d = 1'b0;
        sel_d   = COIN_NONE;
        state_d = FIN;
        if (rem_q <= MAX_CHANGE) begin
          if (rem_q >= QUARTER && !empty_q && !jam_q[2]) begin
            sel_d = COIN_Q; state_d = EJECT;
          end else if (rem_q >= DIME && !empty_d && !jam_q[1]) begin
            sel_d = COIN_D; state_d = EJECT;
          end else if (rem_q >= NICKEL && !empty_n && !jam_q[0]) begin
            sel_d = COIN_N; state_d = EJECT;
          end
        end
      end
      EJECT: begin
        // An early ack is banked but the pulse always runs to full width.
        if (coin_ack && !acked_q) begin
          rem_d   = rem_q - coin_value(sel_q);
          cnt_d   = cnt_q + 7'd1;
          acked_d = 1'b1;
        end
        if (pulse_last)
          state_d = (acked_q || coin_ack) ? SELECT : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (coin_ack) begin
          rem_d   = rem_q - coin_value(sel_q);
          cnt_d   = cnt_q + 7'd1;
          state_d = SELECT;
        end else if (timeout) begin
          jam_d   = jam_q | coin_mask(sel_q);
          state_d = SELECT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= COIN_NONE;
      rem_q   <= '0;
      cnt_q   <= '0;
      jam_q   <= '0;
      acked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      jam_q   <= jam_d;
      acked_q <= acked_d;
    end
  end

  assign {eject_q, eject_d, eject_n} = (state_q == EJECT) ? coin_mask(sel_q) : 3'b000;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign error      = done && (rem_q != 9'd0);
  assign remaining  = rem_q;
  assign coin_count = cnt_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: directed scenarios plus random transactions
// checked against a coin-level reference model and a scripted hopper.
module tb_change_dispenser_ctrl;

  localparam int PULSE = 4;
  localparam int ACK_T = 20;
  localparam int PLAN_N = 128;
  // Hopper plan codes per eject: d>=0 ack d cycles after pulse end,
  // -1..-4 ack in that pulse cycle, -10 two acks in the pulse, -99 never.
  localparam int NEVER = -99;
  localparam int DOUBLE = -10;

  logic clk = 1'b0;
  logic rst_n, start, coin_ack = 1'b0;
  logic [8:0] amount;
  logic empty_q, empty_d, empty_n;
  logic eject_q, eject_d, eject_n, busy, done, error;
  logic [8:0] remaining;
  logic [6:0] coin_count;

  int checks = 0;
  int errors = 0;
  int plan[PLAN_N];
  int plan_idx = 0;
  int obs[$];
  int exp_q[$];
  int m_rem, m_cnt, m_err, m_cyc;

  logic [2:0] ej, prev_ej = 3'b000;
  int h_mode = 0, h_pc = 0, h_cd = -1;

  change_dispenser_ctrl #(.PULSE_CYCLES(PULSE), .ACK_TIMEOUT(ACK_T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount), .coin_ack(coin_ack),
    .empty_q(empty_q), .empty_d(empty_d), .empty_n(empty_n),
    .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
    .busy(busy), .done(done), .error(error),
    .remaining(remaining), .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  // Hopper: acts just after each falling edge, follows the plan per pulse.
  always begin
    @(negedge clk);
    #1;
    ej = {eject_q, eject_d, eject_n};
    coin_ack = 1'b0;
    if (!rst_n) begin
      prev_ej = 3'b000; h_cd = -1; h_mode = 0; h_pc = 0;
    end else begin
      if (start && !busy) begin plan_idx = 0; obs.delete(); end
      if (ej != 3'b000 && prev_ej == 3'b000) begin
        h_mode = (plan_idx < PLAN_N) ? plan[plan_idx] : 0;
        plan_idx++;
        obs.push_back(ej == 3'b100 ? 25 : (ej == 3'b010 ? 10 : 5));
        h_pc = 0; h_cd = -1;
      end
      if (ej != 3'b000) begin
        h_pc++;
        if (h_mode < 0 && h_mode > -5 && h_pc == -h_mode) coin_ack = 1'b1;
        if (h_mode == DOUBLE && (h_pc == 1 || h_pc == 3)) coin_ack = 1'b1;
      end else if (prev_ej != 3'b000 && h_mode >= 0) begin
        h_cd = h_mode;
      end
      if (ej == 3'b000 && h_cd >= 0) begin
        if (h_cd == 0) coin_ack = 1'b1;
        h_cd--;
      end
      prev_ej = ej;
    end
  end

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("eject_onehot", int'($countones({eject_q, eject_d, eject_n}) <= 1), 1);
  endtask

  // Coin-level model: greedy change with jams; cycles = 2 + per coin (1+PULSE+wait).
  task automatic model(input int amt, input bit eq, input bit ed, input bit en, input bit q_drop);
    int vals[3] = '{25, 10, 5};
    bit avail[3];
    bit jam[3];
    int i, c, md, w;
    exp_q.delete();
    avail[0] = !eq; avail[1] = !ed; avail[2] = !en;
    jam[0] = 0; jam[1] = 0; jam[2] = 0;
    m_rem = amt; m_cnt = 0; m_cyc = 2; i = 0;
    if (amt <= 500) begin
      while (1) begin
        c = -1;
        for (int k = 0; k < 3; k++)
          if (c < 0 && m_rem >= vals[k] && avail[k] && !jam[k]) c = k;
        if (c < 0) break;
        md = plan[i]; i++;
        exp_q.push_back(vals[c]);
        if (q_drop && c == 0) avail[0] = 0;
        if (md == NEVER) begin
          jam[c] = 1; w = ACK_T;
        end else begin
          m_rem -= vals[c]; m_cnt++;
          w = (md >= 0) ? md + 1 : 0;
        end
        m_cyc += 1 + PULSE + w;
      end
    end
    m_err = (m_rem != 0) ? 1 : 0;
  endtask

  task automatic fill_plan(input int md);
    for (int i = 0; i < PLAN_N; i++) plan[i] = md;
  endtask

  task automatic run_txn(input string tag, input int amt, input bit eq, input bit ed,
                         input bit en, input bit q_drop);
    int n;
    bit seen;
    model(amt, eq, ed, en, q_drop);
    empty_q = eq; empty_d = ed; empty_n = en;
    amount = amt[8:0];
    start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 4000) begin
      tick();
      start = 1'b0;
      n++;
      if (q_drop && eject_q) empty_q = 1'b1;
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, n, m_cyc);
    chk({tag, "_error"}, int'(error), m_err);
    chk({tag, "_remaining"}, int'(remaining), m_rem);
    chk({tag, "_coin_count"}, int'(coin_count), m_cnt);
    chk({tag, "_busy_fin"}, int'(busy), 1);
    chk({tag, "_n_ejects"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk({tag, "_coin"}, obs[i], exp_q[i]);
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_busy_drop"}, int'(busy), 0);
    chk({tag, "_remaining_hold"}, int'(remaining), m_rem);
    if (!seen) begin
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_ejects"}, int'({eject_q, eject_d, eject_n}), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
    chk({tag, "_coin_count"}, int'(coin_count), 0);
  endtask

  initial begin
    int r;
    bit seen;
    rst_n = 1'b0; start = 1'b0; amount = '0;
    empty_q = 1'b0; empty_d = 1'b0; empty_n = 1'b0;
    fill_plan(3);
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    fill_plan(3);                 run_txn("amt40", 40, 0, 0, 0, 0);
    fill_plan(3);                 run_txn("amt30_noq", 30, 1, 0, 0, 0);
    run_txn("amt3", 3, 0, 0, 0, 0);
    run_txn("amt0", 0, 0, 0, 0, 0);
    fill_plan(3); plan[0] = NEVER; run_txn("q_jam", 25, 0, 0, 0, 0);
    run_txn("amt505", 505, 0, 0, 0, 0);
    fill_plan(0);                 run_txn("amt501", 501, 0, 0, 0, 0);
    fill_plan(0);                 run_txn("amt500", 500, 0, 0, 0, 0);
    fill_plan(-2);                run_txn("early_ack", 40, 0, 0, 0, 0);
    fill_plan(DOUBLE);            run_txn("double_ack", 40, 0, 0, 0, 0);
    fill_plan(0);                 run_txn("q_drop", 50, 0, 0, 0, 1);
    run_txn("all_empty", 20, 1, 1, 1, 0);
    fill_plan(NEVER);             run_txn("all_jam", 40, 0, 0, 0, 0);

    // Reset in the middle of the first quarter pulse.
    fill_plan(3);
    empty_q = 1'b0; empty_d = 1'b0; empty_n = 1'b0;
    amount = 9'd40; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (eject_q) seen = 1;
    end
    chk("rst_mid_eject_seen", int'(seen), 1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    tick();
    chk("rst_mid_no_done", int'(done), 0);
    fill_plan(3);                 run_txn("after_rst", 5, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < PLAN_N; i++) begin
        r = $urandom_range(0, 99);
        if (r < 65)      plan[i] = $urandom_range(0, 5);
        else if (r < 80) plan[i] = -int'($urandom_range(1, 4));
        else if (r < 87) plan[i] = DOUBLE;
        else             plan[i] = NEVER;
      end
      r = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 150) : $urandom_range(0, 511);
      run_txn("rnd", r, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 4) == 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
